// File: rtl/seg7_scan_decoder.sv
// Rebuilds an NDIG-digit hex value from a scanned, active-low 7-segment bus.
// Optional macro SEG7_BLANK_EN: all-segments-off is a legal blank digit reported on blank_mask.
module seg7_scan_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   an_n,
    output logic [4*NDIG-1:0] value,
    output logic              frame_valid,
    output logic              dec_err
`ifdef SEG7_BLANK_EN
    ,
    output logic [NDIG-1:0]   blank_mask
`endif
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // Returns {valid, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = {1'b1, 4'h0};
            7'b1001111: decode = {1'b1, 4'h1};
            7'b0010010: decode = {1'b1, 4'h2};
            7'b0000110: decode = {1'b1, 4'h3};
            7'b1001100: decode = {1'b1, 4'h4};
            7'b0100100: decode = {1'b1, 4'h5};
            7'b0100000: decode = {1'b1, 4'h6};
            7'b0001101: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0000100: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b1100000: decode = {1'b1, 4'hB};
            7'b0110001: decode = {1'b1, 4'hC};
            7'b1000010: decode = {1'b1, 4'hD};
            7'b0110000: decode = {1'b1, 4'hE};
            7'b0111000: decode = {1'b1, 4'hF};
`ifdef SEG7_BLANK_EN
            7'b1111111: decode = {1'b1, 4'h0};
`endif
            default:    decode = 5'b0;
        endcase
    endfunction

    function automatic logic onehot_low(input logic [NDIG-1:0] a);
        return $countones(~a) == 1;
    endfunction

    function automatic logic [IDX_W-1:0] digit_idx(input logic [NDIG-1:0] a);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NDIG; i++)
            if (!a[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [6:0]          seg_s_q, seg_p_q;
    logic [NDIG-1:0]     an_s_q, an_p_q;
    logic [4*NDIG-1:0]   shadow_q, shadow_d, value_q, value_d;
    logic [NDIG-1:0]     mask_q, mask_d;
    logic                fv_q, fv_d, de_q, de_d;
    logic                cap, same, an_ok, dec_ok;
    logic [3:0]          dec_nib;
    logic [IDX_W-1:0]    cap_idx;
`ifdef SEG7_BLANK_EN
    logic [NDIG-1:0]     blank_sh_q, blank_sh_d, blank_mask_q, blank_mask_d;
`endif

    assign same    = (seg_s_q == seg_p_q) && (an_s_q == an_p_q);
    assign an_ok   = onehot_low(an_s_q);
    assign cnt_inc = (cnt_q >= CNT_W'(STABLE_CYC)) ? CNT_W'(STABLE_CYC) : cnt_q + CNT_W'(1);
    assign {dec_ok, dec_nib} = decode(seg_s_q);
    assign cap_idx = digit_idx(an_s_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: if (an_ok) begin
                state_d = SETTLE;
                cnt_d   = CNT_W'(1);
            end
            SETTLE: begin
                if (!an_ok) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(STABLE_CYC)) begin
                        cap     = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: if (!same) begin
                state_d = an_ok ? SETTLE : IDLE;
                cnt_d   = an_ok ? CNT_W'(1) : '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame publish uses the pre-capture shadow; a capture in the same cycle starts the next frame.
    always_comb begin
        shadow_d = shadow_q;
        mask_d   = mask_q;
        value_d  = value_q;
        fv_d     = 1'b0;
        de_d     = 1'b0;
`ifdef SEG7_BLANK_EN
        blank_sh_d   = blank_sh_q;
        blank_mask_d = blank_mask_q;
`endif
        if (&mask_q) begin
            value_d = shadow_q;
            fv_d    = 1'b1;
            mask_d  = '0;
`ifdef SEG7_BLANK_EN
            blank_mask_d = blank_sh_q;
`endif
        end
        if (cap) begin
            if (dec_ok) begin
                shadow_d[{cap_idx, 2'b00} +: 4] = dec_nib;
                mask_d[cap_idx]                 = 1'b1;
`ifdef SEG7_BLANK_EN
                blank_sh_d[cap_idx]             = (seg_s_q == 7'b1111111);
`endif
            end else begin
                de_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            seg_s_q  <= '1;
            seg_p_q  <= '1;
            an_s_q   <= '1;
            an_p_q   <= '1;
            shadow_q <= '0;
            mask_q   <= '0;
            value_q  <= '0;
            fv_q     <= 1'b0;
            de_q     <= 1'b0;
`ifdef SEG7_BLANK_EN
            blank_sh_q   <= '0;
            blank_mask_q <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            seg_s_q  <= seg_n;
            seg_p_q  <= seg_s_q;
            an_s_q   <= an_n;
            an_p_q   <= an_s_q;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            value_q  <= value_d;
            fv_q     <= fv_d;
            de_q     <= de_d;
`ifdef SEG7_BLANK_EN
            blank_sh_q   <= blank_sh_d;
            blank_mask_q <= blank_mask_d;
`endif
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign dec_err     = de_q;
`ifdef SEG7_BLANK_EN
    assign blank_mask  = blank_mask_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans plus random scan sequences against an interval-level model.
module tb_seg7_scan_decoder;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 8;
    localparam int CNT_W      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        seg_n;
    logic [NDIG-1:0]   an_n;
    logic [4*NDIG-1:0] value;
    logic              frame_valid;
    logic              dec_err;
`ifdef SEG7_BLANK_EN
    logic [NDIG-1:0]   blank_mask;
`endif

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .value(value), .frame_valid(frame_valid), .dec_err(dec_err)
`ifdef SEG7_BLANK_EN
        , .blank_mask(blank_mask)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] enc [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    typedef struct {
        logic [6:0]      seg;
        logic [NDIG-1:0] an;
        int              len;
    } ivl_t;

    ivl_t        seq[$];
    logic [63:0] obs_frames[$];
    int          derr_tot = 0;

    logic [3:0]      m_dig [NDIG];
    logic [NDIG-1:0] m_mask, m_blank;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Nibble 0..15, 16 for a legal blank, -1 for an undecodable pattern.
    function automatic int seg_to_nib(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (enc[k] == s) return k;
`ifdef SEG7_BLANK_EN
        if (s == 7'b1111111) return 16;
`endif
        return -1;
    endfunction

    function automatic logic [NDIG-1:0] dsel(input int i);
        return ~(NDIG'(1) << i);
    endfunction

    function automatic logic [63:0] frame_word();
        logic [63:0] w;
        w = 64'(value);
`ifdef SEG7_BLANK_EN
        w = w | (64'(blank_mask) << (4*NDIG));
`endif
        return w;
    endfunction

    always @(negedge clk) begin
        if (frame_valid) obs_frames.push_back(frame_word());
        if (dec_err) derr_tot++;
    end

    task automatic model_reset();
        m_mask  = '0;
        m_blank = '0;
        for (int i = 0; i < NDIG; i++) m_dig[i] = 4'h0;
    endtask

    task automatic add(input logic [6:0] s, input logic [NDIG-1:0] a, input int len);
        ivl_t v;
        v.seg = s;
        v.an  = a;
        v.len = len;
        seq.push_back(v);
    endtask

    // Drives the queued intervals; any interval held at least STABLE_CYC cycles on one digit is one capture.
    task automatic run_seq(input string tag);
        int          f0, d0, exp_derr, d, di;
        logic [63:0] w;
        logic [63:0] exp_f[$];
        f0 = obs_frames.size();
        d0 = derr_tot;
        exp_derr = 0;
        foreach (seq[k]) begin
            seg_n = seq[k].seg;
            an_n  = seq[k].an;
            repeat (seq[k].len) @(negedge clk);
            if ($countones(~seq[k].an) == 1 && seq[k].len >= STABLE_CYC) begin
                d  = seg_to_nib(seq[k].seg);
                di = 0;
                for (int i = 0; i < NDIG; i++) if (!seq[k].an[i]) di = i;
                if (d < 0) begin
                    exp_derr++;
                end else begin
                    m_dig[di]   = (d == 16) ? 4'h0 : d[3:0];
                    m_blank[di] = (d == 16);
                    m_mask[di]  = 1'b1;
                    if (&m_mask) begin
                        w = 64'(m_blank) << (4*NDIG);
                        for (int i = 0; i < NDIG; i++) w[4*i +: 4] = m_dig[i];
                        exp_f.push_back(w);
                        m_mask = '0;
                    end
                end
            end
        end
        seg_n = '1;
        an_n  = '1;
        repeat (20) @(negedge clk);
        chk({tag, "/frames"}, 64'(obs_frames.size() - f0), 64'(exp_f.size()));
        foreach (exp_f[k])
            if (f0 + k < obs_frames.size()) chk({tag, "/value"}, obs_frames[f0 + k], exp_f[k]);
        chk({tag, "/dec_err"}, 64'(derr_tot - d0), 64'(exp_derr));
        seq.delete();
    endtask

    task automatic gen_random(input int n);
        logic [6:0]      s, ps;
        logic [NDIG-1:0] a, pa;
        int              r, len;
        ps = '1;
        pa = '1;
        for (int k = 0; k < n; k++) begin
            do begin
                r = $urandom_range(0, 99);
                s = 7'($urandom_range(0, 127));
                a = dsel($urandom_range(0, NDIG - 1));
                len = $urandom_range(12, 16);
                if (r < 60) begin
                    s = enc[$urandom_range(0, 15)];
                end else if (r < 70) begin
                    while (seg_to_nib(s) >= 0) s = 7'($urandom_range(0, 127));
                end else if (r < 85) begin
                    len = $urandom_range(2, 4);
                end else begin
                    a = NDIG'($urandom_range(0, (1 << NDIG) - 1));
                    while ($countones(~a) == 1) a = NDIG'($urandom_range(0, (1 << NDIG) - 1));
                end
            end while (s == ps && a == pa);
            add(s, a, len);
            ps = s;
            pa = a;
        end
    endtask

    initial begin
        rst   = 1'b1;
        seg_n = '1;
        an_n  = '1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset/value", 64'(value), 64'h0);
        chk("reset/frame_valid", 64'(frame_valid), 64'h0);
        chk("reset/dec_err", 64'(dec_err), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NDIG; i++) add(enc[i + 1], dsel(i), 12);
        run_seq("scan4321");
        chk("scan4321/direct", 64'(value), 64'h4321);

        add(enc[0], dsel(0), 12);
        add(enc[11], dsel(1), 12);
        add(enc[12], dsel(2), 12);
        add(enc[0], dsel(3), 12);
        run_seq("scan0CB0");
        chk("scan0CB0/direct", 64'(value), 64'h0CB0);

        // Two digits captured, then reset lands while digit 2 is settling.
        add(enc[9], dsel(0), 12);
        add(enc[9], dsel(1), 12);
        run_seq("pre_rst");
        seg_n = enc[5];
        an_n  = dsel(2);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst/value", 64'(value), 64'h0);
        chk("midrst/frame_valid", 64'(frame_valid), 64'h0);
        chk("midrst/dec_err", 64'(dec_err), 64'h0);
        seg_n = '1;
        an_n  = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 1; i < NDIG; i++) add(enc[i], dsel(i), 12);
        run_seq("post_rst_partial");
        add(enc[7], dsel(0), 12);
        run_seq("post_rst_full");
        chk("post_rst_full/direct", 64'(value), 64'h3217);

        add(enc[3], dsel(0), 12);
        add(7'b1111110, dsel(1), 12);
        add(enc[3], dsel(2), 12);
        add(enc[3], dsel(3), 12);
        run_seq("bad_digit");
        add(enc[4], dsel(1), 12);
        run_seq("bad_digit_fix");
        chk("bad_digit_fix/direct", 64'(value), 64'h3343);

        for (int k = 0; k < 8; k++) add((k % 2 == 1) ? enc[1] : enc[2], dsel(0), 5);
        add(enc[8], 4'b0011, 20);
        add(7'b1111110, 4'b0011, 20);
        for (int i = 1; i < NDIG; i++) add(enc[6], dsel(i), 12);
        add(enc[5], dsel(0), 12);
        run_seq("toggle");
        chk("toggle/direct", 64'(value), 64'h6665);

        for (int i = 0; i < NDIG - 1; i++) add(enc[7], dsel(i), 12);
        add(7'b1111111, dsel(3), 12);
        run_seq("blank_d3");
`ifdef SEG7_BLANK_EN
        chk("blank_d3/direct", frame_word(), 64'h80777);
`else
        add(enc[1], dsel(3), 12);
        run_seq("blank_d3_fix");
        chk("blank_d3_fix/direct", 64'(value), 64'h1777);
`endif

        for (int r = 0; r < 4; r++) begin
            gen_random(40);
            run_seq($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
